// File: rtl/bram_arb_pkg.sv
// Purpose: shared helpers for the BRAM simple-dual-port arbiter.
//   - MAX_REQ / PTR_W : widest requester vector the helpers handle (8).
//   - idx_width       : index width for an N-way arbiter (at least 1 bit).
//   - onehot_to_idx   : binary index of a one-hot vector (0 when empty).
//   - rr_pick         : round-robin one-hot pick, search starts at ptr and
//                       wraps modulo n.
package bram_arb_pkg;

    localparam int unsigned MAX_REQ = 8;
    localparam int unsigned PTR_W   = 3;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | PTR_W'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [PTR_W-1:0]   ptr,
        input int unsigned        n
    );
        logic [MAX_REQ-1:0] gnt;
        logic               found;
        int unsigned        pos;
        logic [PTR_W-1:0]   sel;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < n) begin
                pos = 32'(ptr) + i;
                if (pos >= n) begin
                    pos = pos - n;
                end
                sel = PTR_W'(pos);
                if (!found && req[sel]) begin
                    gnt[sel] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// Purpose: simple-dual-port block RAM, read-first, registered read data.
// Ports:
//   clk      : clock
//   cs       : chip select, gates both ports
//   wr_en    : write enable, wr_addr/wr_data committed at the clock edge
//   rd_en    : read enable, rd_data updated at the clock edge
//   rd_data  : registered read word; holds when no read is performed
// No reset: contents and the output register are left as-is.
module bram_sdp #(
    parameter int unsigned DATA_BIT_WIDTH  = 32,
    parameter int unsigned DEPTH_BIT_WIDTH = 9
) (
    input  logic                       clk,
    input  logic                       cs,
    input  logic                       wr_en,
    input  logic [DEPTH_BIT_WIDTH-1:0] wr_addr,
    input  logic [DATA_BIT_WIDTH-1:0]  wr_data,
    input  logic                       rd_en,
    input  logic [DEPTH_BIT_WIDTH-1:0] rd_addr,
    output logic [DATA_BIT_WIDTH-1:0]  rd_data
);

    logic [DATA_BIT_WIDTH-1:0] r_mem [0:(2**DEPTH_BIT_WIDTH)-1];
    logic [DATA_BIT_WIDTH-1:0] r_rd_data;

    // Both accesses sample the array before the edge, so a same-address
    // collision returns the old word.
    always_ff @(posedge clk) begin
        if (cs) begin
            if (rd_en) begin
                r_rd_data <= r_mem[rd_addr];
            end
            if (wr_en) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    assign rd_data = r_rd_data;

endmodule

// File: rtl/rr_arb.sv
// Purpose: N-way round-robin arbiter with a registered search pointer.
// Ports:
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   req      : per-requester request
//   adv      : a grant was taken this cycle; pointer moves past the winner
//   gnt      : combinational one-hot grant, forced to 0 during reset
//   ptr      : current search start index
import bram_arb_pkg::*;

module rr_arb #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = idx_width(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             adv,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] ptr
);

    logic [IDX_W-1:0]   r_ptr;
    logic [MAX_REQ-1:0] w_req_ext;
    logic [MAX_REQ-1:0] w_pick;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [IDX_W-1:0]   w_next_ptr;

    always_comb begin
        w_req_ext        = '0;
        w_req_ext[N-1:0] = req;
        w_pick           = rr_pick(w_req_ext, PTR_W'(r_ptr), N);
        gnt              = rst ? '0 : w_pick[N-1:0];
        w_gnt_idx        = onehot_to_idx(w_pick);
        if (32'(w_gnt_idx) == N - 1) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = IDX_W'(w_gnt_idx) + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (adv) begin
            r_ptr <= w_next_ptr;
        end
    end

    assign ptr = r_ptr;

endmodule

// File: rtl/bram_sdp_arbiter.sv
// Purpose: shares one simple-dual-port BRAM between NUM_RD readers and
// NUM_WR writers, each port with its own round-robin arbiter. Read data
// returns one cycle after the grant, tagged with the one-hot requester.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   rd_req/addr   : per-reader request and packed addresses (slice i)
//   rd_gnt        : one-hot combinational read grant
//   rd_rsp_valid  : one-hot response owner, one cycle after the grant
//   rd_rsp_data   : read word; holds its last value between responses
//   wr_req/addr/data : per-writer request, packed addresses and data
//   wr_gnt        : one-hot combinational write grant, commits at the edge
//   busy          : any request pending or response showing
import bram_arb_pkg::*;

module bram_sdp_arbiter #(
    parameter int unsigned DATA_BIT_WIDTH  = 32,
    parameter int unsigned DEPTH_BIT_WIDTH = 9,
    parameter int unsigned NUM_RD          = 4,
    parameter int unsigned NUM_WR          = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_RD-1:0]                   rd_req,
    input  logic [NUM_RD*DEPTH_BIT_WIDTH-1:0]   rd_addr,
    output logic [NUM_RD-1:0]                   rd_gnt,
    output logic [NUM_RD-1:0]                   rd_rsp_valid,
    output logic signed [DATA_BIT_WIDTH-1:0]    rd_rsp_data,
    input  logic [NUM_WR-1:0]                   wr_req,
    input  logic [NUM_WR*DEPTH_BIT_WIDTH-1:0]   wr_addr,
    input  logic [NUM_WR*DATA_BIT_WIDTH-1:0]    wr_data,
    output logic [NUM_WR-1:0]                   wr_gnt,
    output logic                                busy
);

    localparam int unsigned RD_IDX_W = idx_width(NUM_RD);
    localparam int unsigned WR_IDX_W = idx_width(NUM_WR);

    logic [NUM_RD-1:0]          w_rd_gnt;
    logic [NUM_WR-1:0]          w_wr_gnt;
    logic [RD_IDX_W-1:0]        w_rd_ptr;
    logic [WR_IDX_W-1:0]        w_wr_ptr;
    logic                       w_rd_fire;
    logic                       w_wr_fire;
    logic [DEPTH_BIT_WIDTH-1:0] w_rd_addr_sel;
    logic [DEPTH_BIT_WIDTH-1:0] w_wr_addr_sel;
    logic [DATA_BIT_WIDTH-1:0]  w_wr_data_sel;
    logic [DATA_BIT_WIDTH-1:0]  w_bram_q;
    logic                       w_unused_ptrs;

    logic [NUM_RD-1:0]          r_tag;
    logic                       r_has_data;

    rr_arb #(.N(NUM_RD)) u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_req),
        .adv (w_rd_fire),
        .gnt (w_rd_gnt),
        .ptr (w_rd_ptr)
    );

    rr_arb #(.N(NUM_WR)) u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_req),
        .adv (w_wr_fire),
        .gnt (w_wr_gnt),
        .ptr (w_wr_ptr)
    );

    // Pointers are exposed by the arbiters for observation only.
    assign w_unused_ptrs = ^{w_rd_ptr, w_wr_ptr};

    assign w_rd_fire = |w_rd_gnt;
    assign w_wr_fire = |w_wr_gnt;

    // One-hot grants make an AND-OR mux sufficient for the port selects.
    always_comb begin
        w_rd_addr_sel = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (w_rd_gnt[i]) begin
                w_rd_addr_sel = w_rd_addr_sel | rd_addr[i*DEPTH_BIT_WIDTH +: DEPTH_BIT_WIDTH];
            end
        end
    end

    always_comb begin
        w_wr_addr_sel = '0;
        w_wr_data_sel = '0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (w_wr_gnt[i]) begin
                w_wr_addr_sel = w_wr_addr_sel | wr_addr[i*DEPTH_BIT_WIDTH +: DEPTH_BIT_WIDTH];
                w_wr_data_sel = w_wr_data_sel | wr_data[i*DATA_BIT_WIDTH +: DATA_BIT_WIDTH];
            end
        end
    end

    bram_sdp #(
        .DATA_BIT_WIDTH  (DATA_BIT_WIDTH),
        .DEPTH_BIT_WIDTH (DEPTH_BIT_WIDTH)
    ) u_bram (
        .clk     (clk),
        .cs      (w_rd_fire | w_wr_fire),
        .wr_en   (w_wr_fire),
        .wr_addr (w_wr_addr_sel),
        .wr_data (w_wr_data_sel),
        .rd_en   (w_rd_fire),
        .rd_addr (w_rd_addr_sel),
        .rd_data (w_bram_q)
    );

    // r_has_data masks the un-reset BRAM output register until the first
    // read after reset, so rd_rsp_data reads 0 until then.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag      <= '0;
            r_has_data <= 1'b0;
        end else begin
            r_tag <= w_rd_gnt;
            if (w_rd_fire) begin
                r_has_data <= 1'b1;
            end
        end
    end

    // Outputs are masked while rst is high, so a response whose grant edge
    // preceded a reset never shows a valid pulse.
    assign rd_gnt       = w_rd_gnt;
    assign wr_gnt       = w_wr_gnt;
    assign rd_rsp_valid = rst ? '0 : r_tag;
    assign rd_rsp_data  = (rst || !r_has_data) ? '0 : w_bram_q;
    assign busy         = !rst && ((|rd_req) || (|wr_req) || (|r_tag));

endmodule

// File: doc/bram_sdp_arbiter.md
Name: bram_sdp_arbiter

Overview:
- Shares one simple-dual-port block RAM (instantiated internally as bram_sdp) between NUM_RD read requesters and NUM_WR write requesters.
- Each BRAM port has its own round-robin arbiter.
- Returns read data with a fixed latency, tagged by a one-hot requester valid.
- Sits between the DRNN weight/state loaders (writers) and the MAC array fetch units (readers).

Parameters:
- DATA_BIT_WIDTH, 32, BRAM word width.
- DEPTH_BIT_WIDTH, 9, BRAM address width; depth is 2**DEPTH_BIT_WIDTH.
- NUM_RD, 4, number of read requesters (2..8).
- NUM_WR, 2, number of write requesters (1..8).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_req  in  NUM_RD  per-requester read request.
- rd_addr  in  NUM_RD*DEPTH_BIT_WIDTH  packed read addresses; requester i occupies slice i.
- rd_gnt  out  NUM_RD  one-hot grant; request accepted this cycle.
- rd_rsp_valid  out  NUM_RD  one-hot; rd_rsp_data belongs to this requester.
- rd_rsp_data  out  DATA_BIT_WIDTH  signed read data.
- wr_req  in  NUM_WR  per-requester write request.
- wr_addr  in  NUM_WR*DEPTH_BIT_WIDTH  packed write addresses.
- wr_data  in  NUM_WR*DATA_BIT_WIDTH  packed signed write data.
- wr_gnt  out  NUM_WR  one-hot grant; write committed at this clock edge.
- busy  out  1  any request pending or read response in flight.

Behaviour:
- Reset: clock clk, reset rst synchronous active-high. During and after reset, all outputs are 0 and both round-robin pointers reset to requester 0.
- Reset mid-operation: in-flight read responses are dropped, with no rd_rsp_valid pulse. Memory contents are not cleared.
- Grant timing: grants are combinational from the current request vector and the registered pointer. The grant is asserted in the same cycle the request is accepted.
- Request handshake:
  - A requester holds req, addr and data stable until it sees gnt.
  - A transfer occurs when req & gnt are both high at a clock edge.
  - A requester may deassert req without a grant; nothing happens in that case.
- Round-robin:
  - Search starts at pointer, wraps modulo NUM.
  - After a grant to index k, pointer becomes (k+1) mod NUM.
  - With no grant, the pointer holds.
  - A lone requester is granted every cycle (no bubble).
- Read path:
  - Granted address drives the BRAM read port with rd_en=1 and cs=1.
  - BRAM data is registered, so latency is 1 cycle: rd_rsp_valid[k] and rd_rsp_data appear on the edge after the grant edge.
  - A 1-deep tag register holds the one-hot grant.
  - No response backpressure; the requester must sink the data in that cycle.
  - rd_rsp_data holds its last value when rd_rsp_valid is 0.
- Write path: granted address/data drive the BRAM write port with wr_en=1; the write commits at the grant edge.
- Simultaneous read and write:
  - Both ports are arbitrated independently; one read and one write per cycle.
  - Same address in the same cycle returns the OLD word (read-first).
  - The write becomes visible to a read granted on a later cycle.
- Throughput: one read grant and one write grant per cycle maximum.
- busy = |rd_req | |wr_req | (any bit of the response tag register).
- Widths: no arithmetic; addresses are passed through unmodified; DEPTH wrap is the requester's concern.

Decomposition:
- Package bram_arb_pkg:
  - constants RD_IDX_W = $clog2(NUM_RD) and WR_IDX_W.
  - function onehot_to_idx.
  - function rr_pick(req, ptr) returning one-hot.
- Sub-module rr_arb #(N):
  - inputs clk, rst, req[N], adv.
  - outputs gnt[N] (one-hot) and the pointer register.
  - Instantiated twice, once per port.
- bram_sdp is instantiated directly, with cs tied to rd_en|wr_en.

Test Plan:
- Reset: assert rst for 3 cycles with all rd_req=4'b1111 -> all gnt, rd_rsp_valid and busy are 0 during reset. First grant after release goes to rd requester 0.
- Write then read: wr requester 1 writes 0x12345678 to addr 5. Next cycle, rd requester 2 reads addr 5 -> rd_gnt=4'b0100, then one cycle later rd_rsp_valid=4'b0100 and rd_rsp_data=0x12345678.
- Round-robin fairness:
  - rd_req=4'b1111 held 8 cycles -> grants 0,1,2,3,0,1,2,3.
  - Then rd_req=4'b1010 -> grants 1,3,1,3 with no idle cycles.
- Read-first collision: addr 9 holds 0xA, write 0xB to 9 and read 9 in the same cycle -> response 0xA. A read next cycle -> 0xB.
- Reset mid-read: grant a read, assert rst on the following edge -> no rd_rsp_valid pulse, pointers back to 0, and addr 5 still reads 0x12345678 afterwards.
- Concurrent streams: both writers request every cycle for 16 cycles to addresses 0..15 while readers 0 and 3 read those addresses back -> writers alternate grants, and every response matches the scoreboard under read-first ordering.
